// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder: buffers an operand vector, waits a skew delay, streams it into an array edge PE, then holds finished.
module systolic_edge_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int SKEW_W     = 4,
  parameter int FIN_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  input  logic [DATA_WIDTH-1:0]     load_data,
  output logic                      load_ready,
  input  logic                      start,
  input  logic [SKEW_W-1:0]         skew,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_waiting,
  input  logic                      out_ready,
  output logic                      out_finished,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(FIN_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, SKEW, STREAM, FINISH} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [SKEW_W-1:0] skew_cnt;
  logic [FW-1:0] fin_cnt;
  logic load_fire, xfer, nonempty;
  assign load_fire = load_valid && load_ready;
  assign xfer = (state == STREAM) && out_ready;
  // a load coinciding with start joins the vector being started
  assign nonempty = (count != '0) || load_fire;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = !nonempty ? FINISH : (skew != '0) ? SKEW : STREAM;
      SKEW:    if (skew_cnt == SKEW_W'(1)) state_nx = STREAM;
      STREAM:  if (xfer && count == CW'(1)) state_nx = FINISH;
      FINISH:  if (fin_cnt == FW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    out_waiting  = state == STREAM;
    out_finished = state == FINISH;
    busy         = state != IDLE;
    load_ready   = (state == IDLE) && (count < FULL);
    out_data     = out_waiting ? mem[rd_ptr] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      skew_cnt <= '0;
      fin_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      if (load_fire) wr_ptr <= wr_ptr + 1'b1;
      if (xfer) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(load_fire) - CW'(xfer);
      skew_cnt <= (state == IDLE && state_nx == SKEW) ? skew : (state == SKEW) ? skew_cnt - 1'b1 : skew_cnt;
      fin_cnt  <= (state != FINISH && state_nx == FINISH) ? FW'(FIN_CYCLES) : (state == FINISH) ? fin_cnt - 1'b1 : fin_cnt;
      done     <= (state == FINISH) && (state_nx == IDLE);
    end
  end
  always_ff @(posedge clk)
    if (load_fire) mem[wr_ptr] <= load_data;
endmodule

// File: tb/tb_systolic_edge_feeder.sv
// tb_systolic_edge_feeder: randomized scoreboard bench for systolic_edge_feeder against a queue-based vector model.
module tb_systolic_edge_feeder;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int SW = 4;
  localparam int FIN = 4;
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic [SW-1:0] skew = '0;
  logic load_ready, out_waiting, out_finished, busy, done;
  logic [DW-1:0] out_data;
  logic [$clog2(DEPTH):0] count;
  int compared = 0, mismatched = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];

  systolic_edge_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKEW_W(SW), .FIN_CYCLES(FIN)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .skew(skew), .out_data(out_data), .out_waiting(out_waiting), .out_ready(out_ready),
    .out_finished(out_finished), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted operand must be the next expected one
  always @(negedge clk) if (!rst) begin
    if (out_waiting && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_xfer: got data %0h with nothing expected", out_data);
      end else chk("stream_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
    if (!out_waiting) chk("data_zero_when_not_waiting", 64'(out_data), 64'd0);
    if (out_finished) chk("waiting_during_finish", 64'(out_waiting), 64'd0);
  end

  task automatic do_load(input logic [DW-1:0] v);
    bit acc;
    load_valid = 1'b1;
    load_data = v;
    acc = model_q.size() < DEPTH;
    @(negedge clk);
    chk("load_ready", 64'(load_ready), 64'(acc));
    @(posedge clk);
    if (acc) model_q.push_back(v);
    #1 load_valid = 1'b0;
  endtask

  task automatic chk_count(input string name);
    @(negedge clk);
    chk(name, 64'(count), 64'(model_q.size()));
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready low for the first 3 stream cycles
  task automatic run_vec(input int s, input int mode);
    int n, first_wait, waits, fins, first_fin, u_idx, done_idx, stalls;
    n = model_q.size();
    start = 1'b1;
    skew = SW'(s);
    @(posedge clk);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    model_q.delete();
    #1 start = 1'b0;
    first_wait = -1; first_fin = -1; waits = 0; fins = 0; u_idx = 0; done_idx = -1; stalls = 0;
    for (int idx = 1; idx <= 300; idx++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : !(out_waiting && stalls < 3);
      if (mode == 2 && !out_ready) stalls++;
      @(negedge clk);
      #1;
      if (out_waiting) begin
        waits++;
        if (first_wait < 0) first_wait = idx;
        if (out_ready) u_idx = idx;
        else if (exp_q.size() > 0) begin
          chk("stall_hold_data", 64'(out_data), 64'(exp_q[0]));
          chk("stall_count", 64'(count), 64'(exp_q.size()));
        end
      end
      if (out_finished) begin
        fins++;
        if (first_fin < 0) first_fin = idx;
      end
      if (done) begin
        done_idx = idx;
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_count", 64'(count), 64'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (done_idx < 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done within 300 cycles, required one");
    end else begin
      if (n > 0) chk("first_wait", 64'(first_wait), 64'(s + 1));
      if (mode == 0 || n == 0) chk("wait_cycles", 64'(waits), 64'(n));
      chk("fin_cycles", 64'(fins), 64'(FIN));
      chk("fin_start", 64'(first_fin), 64'(u_idx + 1));
      chk("done_at", 64'(done_idx), 64'(u_idx + FIN + 1));
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_waiting", 64'(out_waiting), 64'd0);
    chk("rst_out_finished", 64'(out_finished), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    // basic stream
    for (int i = 5; i <= 7; i++) do_load(DW'(i));
    run_vec(0, 0);
    // backpressure
    do_load(32'hA);
    do_load(32'hB);
    run_vec(0, 2);
    // skew
    do_load(32'h55);
    run_vec(3, 0);
    // full and wrap
    for (int i = 0; i < 16; i++) do_load(DW'(i));
    do_load(32'hDEAD);
    chk_count("count_full");
    run_vec(0, 0);
    for (int i = 32; i < 36; i++) do_load(DW'(i));
    run_vec(1, 1);
    // empty start
    run_vec(2, 0);
    // abort mid-stream
    for (int i = 0; i < 4; i++) do_load(DW'(32'h100 + i));
    start = 1'b1;
    skew = '0;
    out_ready = 1'b1;
    @(posedge clk);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    model_q.delete();
    #1 start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_count", 64'(count), 64'd0);
    chk("abort_waiting", 64'(out_waiting), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_finish", 64'(out_finished), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    // randomized vectors
    for (int it = 0; it < 14; it++) begin
      int n;
      n = $urandom_range(0, 17);
      for (int i = 0; i < n; i++) do_load($urandom);
      chk_count("rand_count");
      run_vec($urandom_range(0, 15), $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule

// File: doc/systolic_edge_feeder.md
# systolic_edge_feeder

Operand injector for one row or column edge of the systolic MAC array. It buffers an operand vector written by the host/controller, waits a programmable skew delay, then streams the vector into the first processing element using that element's waiting/ready/finished handshake. It holds finished to close the dot product, so the PE publishes its accumulated C value. One instance per array edge lane: A feeders on rows, B feeders on columns.

## Interface
- DATA_WIDTH, 32, operand width; matches the PE data width.
- DEPTH, 16, buffer entries; power of two, at least 2.
- SKEW_W, 4, width of the skew input.
- FIN_CYCLES, 4, cycles out_finished is held high; at least 1.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_valid  in  1  host offers load_data.
- load_data  in  DATA_WIDTH  operand to append to the buffer.
- load_ready  out  1  buffer accepts a load this cycle.
- start  in  1  begin streaming the buffered vector; one-cycle pulse.
- skew  in  SKEW_W  cycles to delay the first element; sampled with start.
- out_data  out  DATA_WIDTH  operand to the PE (drives PE A_in/B_in).
- out_waiting  out  1  out_data is valid (drives PE *_in_waiting).
- out_ready  in  1  PE can take an operand (from PE *_in_ready).
- out_finished  out  1  vector complete (drives PE *_in_finished).
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the block returns to IDLE.
- count  out  $clog2(DEPTH)+1  number of occupied buffer entries.

## Operation
- Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. count is a separate register.
- States: IDLE, SKEW, STREAM, FINISH. State is registered, and all handshake outputs are Moore-decoded from state. There is no combinational path from out_ready to out_waiting.
- IDLE:
  - load_ready = (count < DEPTH).
  - A load occurs when load_valid && load_ready: buf[wr_ptr] <= load_data, wr_ptr++, count++.
  - start with count > 0 and skew > 0: go to SKEW, skew_cnt <= skew.
  - start with count > 0 and skew == 0: go to STREAM.
  - start with count == 0: go to FINISH. An empty vector still produces the finished window.
  - If start and a load occur in the same cycle, the load is accepted and the new entry is included in the stream.
- SKEW: skew_cnt decrements each cycle. Go to STREAM on the cycle skew_cnt == 1.
- STREAM:
  - out_waiting = 1 and out_data = buf[rd_ptr].
  - A transfer occurs on a cycle with out_ready == 1: rd_ptr++, count--.
  - If the transfer takes count from 1 to 0, go to FINISH.
  - While out_ready is low, out_data and out_waiting are held stable.
- FINISH:
  - out_finished = 1 and out_waiting = 0 for exactly FIN_CYCLES cycles, counted by fin_cnt.
  - Then go to IDLE and assert done for that one transition cycle.
- Outside IDLE: load_ready = 0, loads are dropped, and start is ignored.
- out_data = 0 whenever out_waiting = 0.
- Reset values: state IDLE, count 0, both pointers 0, skew_cnt 0, fin_cnt 0. Outputs: out_data 0, out_waiting 0, out_finished 0, busy 0, done 0, load_ready 1.
- Buffer contents are not reset and are don't-care after reset.
- rst asserted in any state aborts the vector immediately. No finished is emitted.

## Timing
- start sampled high at edge t with skew = S > 0: out_waiting first high in the cycle after edge t+S.
- start sampled high at edge t with S = 0: out_waiting high in the cycle after edge t.
- Throughput: one element per cycle while out_ready is held high. An N-element vector occupies STREAM for N cycles minimum.
- The last transfer at edge u puts out_finished high in cycles u+1 .. u+FIN_CYCLES.
- done is high in cycle u+FIN_CYCLES+1 together with busy = 0. The next start is accepted in that same cycle.
- load_ready reflects count registered at the previous edge. A load in the cycle count == DEPTH-1 is accepted, after which load_ready drops.

## Test plan
- Reset check: after rst, all outputs are at their reset values.
  - Load 3 values (5, 6, 7), then start with skew = 0 and out_ready held at 1.
  - out_data must be 5, 6, 7 on 3 consecutive cycles with out_waiting = 1.
  - Then out_finished = 1 for 4 cycles, then a done pulse, and count = 0.
- Backpressure: load 2 values (0xA, 0xB), start, and hold out_ready low for 3 cycles.
  - out_data must stay 0xA with out_waiting = 1 throughout, with no pointer advance.
  - Then raise out_ready: 0xA, then 0xB transfer.
- Skew: load 1 value and start with skew = 3.
  - out_waiting must first rise exactly 4 cycles after the start edge.
- Full and wrap: load 16 values (0..15). The 17th load is refused (load_ready = 0) and count = 16.
  - Stream all 16 in order.
  - Load 4 more values (0x20..0x23) and stream them; they must come out in order across pointer wrap.
- Empty start and abort:
  - start with count = 0 must give out_finished for 4 cycles, never out_waiting, then done.
  - Separately, assert rst mid-STREAM: the next cycle must show IDLE, count 0, and out_finished 0.
